// File: rtl/pll_lock_reset.sv
// Lock-qualified reset generator: waits for a stable synchronized PLL lock,
// holds the downstream reset for a few more cycles, then releases it until lock is lost.
module pll_lock_reset #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       reset_out,
  output logic       ready,
  output logic [1:0] state_out,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

  logic        sync1, sync2;
  logic        locked_s;
  state_t      state, next_state;
  logic [15:0] cnt, next_cnt;
  logic [7:0]  loss, next_loss;
  logic        reset_out_r, ready_r;

  // Two-flop synchronizer: the only consumer of the raw lock flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= locked;
      sync2 <= sync1;
    end
  end

  assign locked_s = sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      loss        <= '0;
      reset_out_r <= 1'b1;
      ready_r     <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      loss        <= next_loss;
      reset_out_r <= (next_state != RUN);
      ready_r     <= (next_state == RUN);
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = '0;
    next_loss  = loss;
    unique case (state)
      WAIT_LOCK: begin
        if (locked_s) next_state = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          next_state = HOLD;
        end else begin
          next_cnt = cnt + 16'd1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          if (loss != '1) next_loss = loss + 8'd1;
        end else if (cnt == HOLD_LAST) begin
          next_state = RUN;
        end else begin
          next_cnt = cnt + 16'd1;
        end
      end
      RUN: begin
        // Lock loss outranks a coincident soft reset request.
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          if (loss != '1) next_loss = loss + 8'd1;
        end else if (soft_reset) begin
          next_state = HOLD;
        end
      end
      default: next_state = WAIT_LOCK;
    endcase
  end

  assign reset_out  = reset_out_r;
  assign ready      = ready_r;
  assign state_out  = state;
  assign loss_count = loss;

endmodule

// File: tb/tb_pll_lock_reset.sv
// Self-checking bench for pll_lock_reset: directed scenarios plus randomized lock/soft-reset
// traffic compared against a timeline-based reference model.
module tb_pll_lock_reset;

  localparam int S = 4;
  localparam int H = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       reset_out;
  logic       ready;
  logic [1:0] state_out;
  logic [7:0] loss_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: lock history plus "cycles elapsed since lock sequence began".
  int  h1 = 0, h2 = 0;
  bit  active = 0;
  int  elapsed = 0;
  int  mloss = 0;

  pll_lock_reset #(.STABLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clock(clock), .reset(reset), .locked(locked), .soft_reset(soft_reset),
    .reset_out(reset_out), .ready(ready), .state_out(state_out), .loss_count(loss_count)
  );

  always #5 clock = ~clock;

  function automatic int mstate();
    if (!active) return 0;
    if (elapsed < S) return 1;
    if (elapsed < S + H) return 2;
    return 3;
  endfunction

  task automatic model_edge();
    int ls, st;
    if (reset) begin
      h1 = 0; h2 = 0; active = 0; elapsed = 0; mloss = 0;
    end else begin
      ls = h2; h2 = h1; h1 = int'(locked);
      if (active) begin
        st = mstate();
        if (ls == 0) begin
          if (st >= 2 && mloss < 255) mloss++;
          active = 0;
        end else if (st == 3) begin
          if (soft_reset) elapsed = S;
        end else begin
          elapsed++;
        end
      end else if (ls != 0) begin
        active = 1;
        elapsed = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    int st;
    st = mstate();
    chk("state_out", int'(state_out), st);
    chk("reset_out", int'(reset_out), (st != 3) ? 1 : 0);
    chk("ready", int'(ready), (st == 3) ? 1 : 0);
    chk("loss_count", int'(loss_count), mloss);
  endtask

  task automatic cycle(input logic l, input logic s, input logic r);
    @(negedge clock);
    locked = l; soft_reset = s; reset = r;
    @(posedge clock);
    model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    int base;
    // Reset with lock already high: sequence must restart from scratch.
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    chk("rst_state", int'(state_out), 0);
    chk("rst_reset_out", int'(reset_out), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_loss", int'(loss_count), 0);

    // Release latency: edge 1 is the first edge sampling locked high.
    for (int k = 1; k <= 10; k++) begin
      cycle(1, 0, 0);
      if (k == 3) chk("seq_stabilize", int'(state_out), 1);
      if (k == 7) chk("seq_hold", int'(state_out), 2);
      if (k == 8) chk("rel_edge8", int'(reset_out), 1);
      if (k == 9) begin
        chk("rel_edge9", int'(reset_out), 0);
        chk("rel_ready9", int'(ready), 1);
        chk("seq_run", int'(state_out), 3);
      end
    end

    // Soft reset in RUN: two cycles of reset, no loss counted.
    cycle(1, 1, 0);
    chk("soft_asserted", int'(reset_out), 1);
    chk("soft_hold", int'(state_out), 2);
    cycle(1, 0, 0);
    chk("soft_still", int'(reset_out), 1);
    cycle(1, 0, 0);
    chk("soft_released", int'(reset_out), 0);
    chk("soft_noloss", int'(loss_count), 0);

    // Lock drop in RUN: reset rises on the 3rd edge sampling low.
    cycle(0, 0, 0);
    chk("drop_e1", int'(reset_out), 0);
    cycle(0, 0, 0);
    chk("drop_e2", int'(reset_out), 0);
    cycle(0, 0, 0);
    chk("drop_e3", int'(reset_out), 1);
    chk("drop_state", int'(state_out), 0);
    chk("drop_loss", int'(loss_count), 1);
    for (int k = 1; k <= 9; k++) begin
      cycle(1, 0, 0);
      if (k == 8) chk("relock_e8", int'(reset_out), 1);
      if (k == 9) chk("relock_e9", int'(reset_out), 0);
    end

    // Soft reset coincident with the synchronized lock fall: loss wins.
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("coinc_state", int'(state_out), 0);
    chk("coinc_loss", int'(loss_count), 2);

    // Glitch during STABILIZE: never reaches HOLD, no loss, restart from zero.
    for (int k = 0; k < 4; k++) cycle(0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 0);
      chk("glitch_nohold", int'(state_out == 2'd2), 0);
    end
    chk("glitch_loss", int'(loss_count), 2);
    for (int k = 0; k < 8; k++) cycle(1, 0, 0);
    chk("glitch_run", int'(ready), 1);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++)
      cycle(($urandom_range(0, 99) < 96), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 399) == 0));

    // Saturation: 300 lock losses from RUN.
    cycle(0, 0, 1);
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 10; k++) cycle(1, 0, 0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0);
    end
    base = int'(loss_count);
    chk("sat_loss", base, 255);
    cycle(0, 0, 1);
    chk("sat_reset_loss", int'(loss_count), 0);
    chk("sat_reset_out", int'(reset_out), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
